// File: rtl/red_pitaya_dfilt2.sv
// Equalisation filter (BB zero, AA/PP poles, KK gain) with shadowed coefficients.
// Optional saturation counter: define DFILT_SATCNT_EN.
module red_pitaya_dfilt2 #(
    parameter int DW    = 14,
    parameter int AW    = 18,
    parameter int CW    = 25,
    parameter int FLUSH = 4
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rstn_i,
    input  logic signed [DW-1:0] adc_dat_i,
    output logic signed [DW-1:0] adc_dat_o,
    input  logic signed [AW-1:0] cfg_aa_i,
    input  logic signed [CW-1:0] cfg_bb_i,
    input  logic signed [CW-1:0] cfg_kk_i,
    input  logic signed [CW-1:0] cfg_pp_i,
    input  logic                 cfg_upd_i,
    input  logic                 cfg_flush_i,
    output logic                 cfg_ack_o,
    input  logic                 bypass_i,
    output logic                 sat_o,
    output logic [15:0]          sat_cnt_o,
    input  logic                 sat_clr_i
);

    localparam int FW  = DW + 9;
    localparam int HW  = DW + 1;
    localparam int BW  = CW + DW;
    localparam int PW  = CW + HW;
    localparam int AGW = AW + FW;
    localparam int SW  = BW + 2;

    localparam logic signed [PW-1:0] YMAX = PW'((2**(DW-1)) - 1);
    localparam logic signed [PW-1:0] YMIN = PW'(-(2**(DW-1)));

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_APPLY = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]           r_state;
    logic [3:0]           r_fcnt;
    logic                 r_sh_flush;
    logic signed [AW-1:0] r_sh_aa, r_aa;
    logic signed [CW-1:0] r_sh_bb, r_bb;
    logic signed [CW-1:0] r_sh_kk, r_kk;
    logic signed [CW-1:0] r_sh_pp, r_pp;

    logic signed [DW-1:0] r_x0, r_x1, r_x2;
    logic signed [BW-1:0] r_bbx;
    logic signed [FW-1:0] r_f, r_g;
    logic signed [HW-1:0] r_h;
    logic signed [PW-1:0] r_kh;
    logic signed [DW-1:0] r_y, r_y2;
    logic                 r_sat, r_sat2;
    logic signed [DW-1:0] r_dly [0:7];

    logic signed [SW-1:0]  w_fir;
    logic signed [FW-1:0]  w_f;
    logic signed [AGW-1:0] w_aag;
    logic signed [FW-1:0]  w_g_nxt;
    logic signed [PW-1:0]  w_pph;
    logic signed [HW-1:0]  w_h_nxt;
    logic signed [PW-1:0]  w_ks;
    logic                  w_clr;

    assign w_clr     = (r_state == S_FLUSH);
    assign cfg_ack_o = (r_state == S_APPLY);

    assign w_fir   = (SW'(r_x1) <<< 18) + SW'(r_bbx >>> 10)
                   - (SW'(r_x2) <<< 18);
    assign w_f     = FW'(w_fir >>> 10);
    assign w_aag   = AGW'(r_aa) * AGW'(r_g);
    assign w_g_nxt = r_g + r_f - FW'(w_aag >>> 25);
    assign w_pph   = PW'(r_pp) * PW'(r_h);
    assign w_h_nxt = HW'(r_g >>> 8) + HW'(w_pph >>> 16);
    assign w_ks    = r_kh >>> 24;

    // Coefficient handshake: stage into shadow, then swap active set atomically
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_state    <= S_IDLE;
            r_fcnt     <= '0;
            r_sh_flush <= 1'b0;
            r_sh_aa    <= '0;
            r_sh_bb    <= '0;
            r_sh_kk    <= '0;
            r_sh_pp    <= '0;
            r_aa       <= '0;
            r_bb       <= '0;
            r_kk       <= '0;
            r_pp       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (cfg_upd_i) begin
                        r_sh_aa    <= cfg_aa_i;
                        r_sh_bb    <= cfg_bb_i;
                        r_sh_kk    <= cfg_kk_i;
                        r_sh_pp    <= cfg_pp_i;
                        r_sh_flush <= cfg_flush_i;
                        r_state    <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    r_aa    <= r_sh_aa;
                    r_bb    <= r_sh_bb;
                    r_kk    <= r_sh_kk;
                    r_pp    <= r_sh_pp;
                    r_state <= S_APPLY;
                end
                S_APPLY: begin
                    if (r_sh_flush) begin
                        r_fcnt  <= 4'(FLUSH - 1);
                        r_state <= S_FLUSH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (r_fcnt == 4'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_fcnt <= r_fcnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Filter datapath; the two recursive stages keep single-cycle feedback
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_x0   <= '0;
            r_x1   <= '0;
            r_x2   <= '0;
            r_bbx  <= '0;
            r_f    <= '0;
            r_g    <= '0;
            r_h    <= '0;
            r_kh   <= '0;
            r_y    <= '0;
            r_y2   <= '0;
            r_sat  <= 1'b0;
            r_sat2 <= 1'b0;
        end else if (w_clr) begin
            r_x0   <= '0;
            r_x1   <= '0;
            r_x2   <= '0;
            r_bbx  <= '0;
            r_f    <= '0;
            r_g    <= '0;
            r_h    <= '0;
            r_kh   <= '0;
            r_y    <= '0;
            r_y2   <= '0;
            r_sat  <= 1'b0;
            r_sat2 <= 1'b0;
        end else begin
            r_x0  <= adc_dat_i;
            r_x1  <= r_x0;
            r_x2  <= r_x1;
            r_bbx <= BW'(r_bb) * BW'(r_x1);
            r_f   <= w_f;
            r_g   <= w_g_nxt;
            r_h   <= w_h_nxt;
            r_kh  <= PW'(r_kk) * PW'(r_h);
            if (w_ks > YMAX) begin
                r_y   <= DW'(YMAX);
                r_sat <= 1'b1;
            end else if (w_ks < YMIN) begin
                r_y   <= DW'(YMIN);
                r_sat <= 1'b1;
            end else begin
                r_y   <= DW'(w_ks);
                r_sat <= 1'b0;
            end
            r_y2   <= r_y;
            r_sat2 <= r_sat;
        end
    end

    // Bypass delay line runs unconditionally so bypass toggles keep timing
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            for (int i = 0; i < 8; i++) r_dly[i] <= '0;
        end else begin
            r_dly[0] <= adc_dat_i;
            for (int i = 1; i < 8; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    // Output stage: bypass select, hold during flush
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            adc_dat_o <= '0;
            sat_o     <= 1'b0;
        end else if (bypass_i) begin
            adc_dat_o <= r_dly[7];
            sat_o     <= 1'b0;
        end else if (w_clr) begin
            sat_o     <= 1'b0;
        end else begin
            adc_dat_o <= r_y2;
            sat_o     <= r_sat2;
        end
    end

`ifdef DFILT_SATCNT_EN
    logic [15:0] r_sat_cnt;

    // Sticky clip counter; clear has priority
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_sat_cnt <= '0;
        end else if (sat_clr_i) begin
            r_sat_cnt <= '0;
        end else if (sat_o && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_cnt_o = r_sat_cnt;
`else
    logic w_unused_clr;

    assign w_unused_clr = sat_clr_i;
    assign sat_cnt_o    = '0;
`endif

endmodule
